// File: rtl/ucie_ctl_pkg.sv
// Shared link-state and state-request encodings for the UCIe controller RX/TX sides.
package ucie_ctl_pkg;

  typedef enum logic [1:0] {
    REQ_NOP     = 2'b00,
    REQ_ACTIVE  = 2'b01,
    REQ_RETRAIN = 2'b10,
    REQ_RESET   = 2'b11
  } state_req_e;

  typedef enum logic [1:0] {
    ST_RESET     = 2'b00,
    ST_ACTIVE    = 2'b01,
    ST_RETRAIN   = 2'b10,
    ST_LINKERROR = 2'b11
  } link_state_e;

endpackage

// File: rtl/ucie_ctl_rx_fifo_mem.sv
// RX FIFO storage: DEPTH x NBYTES, one synchronous write port, one asynchronous read port.
module ucie_ctl_rx_fifo_mem #(
  parameter int NBYTES = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [NBYTES-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [NBYTES-1:0]        rdata
);

  logic [NBYTES-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ucie_ctl_rx_fifo_ctrl.sv
// RX FIFO controller: link-state FSM gating an RDI->FDI first-word-fall-through FIFO with credits.
module ucie_ctl_rx_fifo_ctrl
  import ucie_ctl_pkg::*;
#(
  parameter int NBYTES    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_state_request,
  input  logic [NBYTES-1:0]        i_rdi_pl_data,
  input  logic                     i_rdi_pl_valid,
  input  logic                     i_fdi_ready,
  output logic [NBYTES-1:0]        o_fdi_data,
  output logic                     o_fdi_data_valid,
  output logic                     o_overflow_detected,
  output logic                     o_credit_return,
  output logic [$clog2(DEPTH):0]   o_credit_avail,
  output logic                     o_almost_full,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  link_state_e   state;
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          full, push_req, push, pop, ovf;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = (state == ST_ACTIVE) && i_rdi_pl_valid;
  assign pop      = o_fdi_data_valid && i_fdi_ready;
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;

  assign o_fdi_data_valid = (count != '0) && (state == ST_ACTIVE);
  assign o_credit_avail   = PW'(DEPTH) - count;
  assign o_almost_full    = count >= PW'(AF_THRESH);
  assign o_state          = state;

  ucie_ctl_rx_fifo_mem #(
    .NBYTES(NBYTES),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (i_clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(i_rdi_pl_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(o_fdi_data)
  );

  // Pointer updates come first so the flush assignments in the FSM case win on the transition edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= ST_RESET;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      o_overflow_detected <= 1'b0;
      o_credit_return     <= 1'b0;
    end else begin
      o_credit_return <= pop;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case (state)
        ST_RESET: begin
          if (i_state_request == REQ_ACTIVE) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (ovf) begin
            state               <= ST_LINKERROR;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            o_overflow_detected <= 1'b1;
          end else if (i_state_request == REQ_RETRAIN) begin
            state <= ST_RETRAIN;
          end else if (i_state_request == REQ_RESET) begin
            state               <= ST_RESET;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            o_overflow_detected <= 1'b0;
          end
        end
        ST_RETRAIN: begin
          if (i_state_request == REQ_ACTIVE) begin
            state <= ST_ACTIVE;
          end else if (i_state_request == REQ_RESET) begin
            state               <= ST_RESET;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            o_overflow_detected <= 1'b0;
          end
        end
        ST_LINKERROR: begin
          if (i_state_request == REQ_RESET) begin
            state               <= ST_RESET;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            o_overflow_detected <= 1'b0;
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_ctl_rx_fifo_ctrl.sv
// Directed bench for ucie_ctl_rx_fifo_ctrl with NBYTES=32, DEPTH=4, AF_THRESH=2.
module tb_ucie_ctl_rx_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] rdi_data = '0;
  logic        rdi_valid = 1'b0;
  logic        fdi_ready = 1'b0;
  logic [31:0] fdi_data;
  logic        fdi_valid;
  logic        overflow;
  logic        credit_return;
  logic [2:0]  credit_avail;
  logic        almost_full;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int pulses;

  ucie_ctl_rx_fifo_ctrl #(
    .NBYTES   (32),
    .DEPTH    (4),
    .AF_THRESH(2)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_state_request    (req),
    .i_rdi_pl_data      (rdi_data),
    .i_rdi_pl_valid     (rdi_valid),
    .i_fdi_ready        (fdi_ready),
    .o_fdi_data         (fdi_data),
    .o_fdi_data_valid   (fdi_valid),
    .o_overflow_detected(overflow),
    .o_credit_return    (credit_return),
    .o_credit_avail     (credit_avail),
    .o_almost_full      (almost_full),
    .o_state            (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    tick();
    chk("rst_valid", {31'd0, fdi_valid}, 32'd0);
    chk("rst_avail", {29'd0, credit_avail}, 32'd4);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_credit", {31'd0, credit_return}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic push then drain
    req = 2'b01; tick(); req = 2'b00;
    chk("act_state", {30'd0, state}, 32'd1);
    rdi_valid = 1'b1; rdi_data = 32'hA1; tick();
    chk("lat_valid", {31'd0, fdi_valid}, 32'd1);
    chk("lat_data", fdi_data, 32'hA1);
    rdi_data = 32'hA2; tick(); rdi_valid = 1'b0;
    chk("two_avail", {29'd0, credit_avail}, 32'd2);
    chk("two_af", {31'd0, almost_full}, 32'd1);
    fdi_ready = 1'b1;
    chk("head_a1", fdi_data, 32'hA1);
    tick();
    chk("cr_a1", {31'd0, credit_return}, 32'd1);
    chk("head_a2", fdi_data, 32'hA2);
    tick();
    chk("cr_a2", {31'd0, credit_return}, 32'd1);
    chk("empty_valid", {31'd0, fdi_valid}, 32'd0);
    tick();
    chk("ready_empty_cr", {31'd0, credit_return}, 32'd0);
    chk("empty_avail", {29'd0, credit_avail}, 32'd4);
    fdi_ready = 1'b0;

    // Overflow into LINKERROR, recover via RESET
    rdi_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdi_data = 32'hB0 + i; tick();
    end
    chk("full_avail", {29'd0, credit_avail}, 32'd0);
    rdi_data = 32'hFF; tick(); rdi_valid = 1'b0;
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_state", {30'd0, state}, 32'd3);
    chk("ovf_valid", {31'd0, fdi_valid}, 32'd0);
    chk("ovf_flushed", {29'd0, credit_avail}, 32'd4);
    req = 2'b01; tick();
    chk("le_ignore_act", {30'd0, state}, 32'd3);
    chk("le_sticky", {31'd0, overflow}, 32'd1);
    req = 2'b11; tick();
    chk("le_rst_state", {30'd0, state}, 32'd0);
    chk("le_rst_flag", {31'd0, overflow}, 32'd0);
    req = 2'b01; tick(); req = 2'b00;

    // Push and pop on a full FIFO
    rdi_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdi_data = 32'hC0 + i; tick();
    end
    rdi_data = 32'h55; fdi_ready = 1'b1;
    chk("fp_head", fdi_data, 32'hC0);
    tick(); rdi_valid = 1'b0;
    chk("fp_no_ovf", {31'd0, overflow}, 32'd0);
    chk("fp_avail", {29'd0, credit_avail}, 32'd0);
    chk("fp_state", {30'd0, state}, 32'd1);
    chk("fp_c1", fdi_data, 32'hC1);
    tick(); chk("fp_c2", fdi_data, 32'hC2);
    tick(); chk("fp_c3", fdi_data, 32'hC3);
    tick(); chk("fp_55", fdi_data, 32'h55);
    chk("fp_avail3", {29'd0, credit_avail}, 32'd3);
    tick(); chk("fp_empty", {31'd0, fdi_valid}, 32'd0);
    fdi_ready = 1'b0;

    // RETRAIN keeps contents and drops pushes
    rdi_valid = 1'b1;
    rdi_data = 32'hD0; tick();
    rdi_data = 32'hD1; tick();
    rdi_valid = 1'b0;
    req = 2'b10; tick(); req = 2'b00;
    chk("rt_state", {30'd0, state}, 32'd2);
    chk("rt_valid", {31'd0, fdi_valid}, 32'd0);
    rdi_valid = 1'b1; rdi_data = 32'hEE; fdi_ready = 1'b1; tick();
    rdi_valid = 1'b0; fdi_ready = 1'b0;
    chk("rt_drop", {29'd0, credit_avail}, 32'd2);
    chk("rt_no_cr", {31'd0, credit_return}, 32'd0);
    req = 2'b01; tick(); req = 2'b00;
    chk("rt_back_d0", fdi_data, 32'hD0);
    chk("rt_back_valid", {31'd0, fdi_valid}, 32'd1);
    fdi_ready = 1'b1; tick();
    chk("rt_back_d1", fdi_data, 32'hD1);
    tick();
    chk("rt_drained", {31'd0, fdi_valid}, 32'd0);
    fdi_ready = 1'b0;

    // Streaming across pointer wrap
    tick();
    pulses = 0;
    fdi_ready = 1'b1; rdi_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rdi_data = 32'h100 + i; tick();
      pulses += int'(credit_return);
      chk("wrap_data", fdi_data, 32'h100 + i);
    end
    rdi_valid = 1'b0; tick();
    pulses += int'(credit_return);
    chk("wrap_pulses", pulses, 32'd10);
    chk("wrap_no_ovf", {31'd0, overflow}, 32'd0);
    chk("wrap_empty", {29'd0, credit_avail}, 32'd4);
    fdi_ready = 1'b0; tick();

    // Async reset mid-transfer
    rdi_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdi_data = 32'hE0 + i; tick();
    end
    rdi_valid = 1'b0;
    chk("pre_rst_avail", {29'd0, credit_avail}, 32'd1);
    #1 rst = 1'b1; #1;
    chk("arst_valid", {31'd0, fdi_valid}, 32'd0);
    chk("arst_avail", {29'd0, credit_avail}, 32'd4);
    chk("arst_state", {30'd0, state}, 32'd0);
    #1 rst = 1'b0;
    rdi_valid = 1'b1; rdi_data = 32'hF0; tick(); rdi_valid = 1'b0;
    chk("post_rst_drop", {29'd0, credit_avail}, 32'd4);
    chk("post_rst_state", {30'd0, state}, 32'd0);
    req = 2'b01; tick(); req = 2'b00;
    chk("post_rst_act", {30'd0, state}, 32'd1);
    chk("post_rst_empty", {31'd0, fdi_valid}, 32'd0);
    chk("post_rst_no_cr", {31'd0, credit_return}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
